// File: rtl/mips_fetch_pkg.sv
// Shared fetch-path constants: FSM state encoding, PC step, halt opcode, counter width.
package mips_fetch_pkg;
  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam int          PC_STEP        = 4;
  localparam logic [31:0] DEF_HALT_INSTR = 32'hFFFF_FFFF;
  localparam int          FETCH_CNT_W    = 16;
endpackage

// File: rtl/fetch_pc_sel.sv
// Next fetch-address mux (reset/boot/redirect/stall/halt/increment); purely combinational, 0 cycles.
// Backpressure: stall or an accepted halt word re-presents pc_f so the ROM output stays put.
module fetch_pc_sel
  import mips_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  reset,
  input  logic [1:0]            state,
  input  logic [ADDR_WIDTH-1:0] pc_f,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  input  logic                  halt_hit,
  output logic [ADDR_WIDTH-1:0] next_pc
);
  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(PC_STEP);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  // Increment relies on natural truncation for the modulo 2^ADDR_WIDTH wrap.
  always_comb begin
    next_pc = pc_f;
    if (reset || state == ST_BOOT) begin
      next_pc = RESET_PC;
    end else if (state == ST_RUN) begin
      if (redirect_valid)
        next_pc = redirect_target & ALIGN_MASK;
      else if (stall || halt_hit)
        next_pc = pc_f;
      else
        next_pc = pc_f + STEP;
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// PC/fetch sequencer in front of a sync-read ROM; one boot bubble after reset, then zero-bubble fetch.
// Backpressure: stall holds if_pc/if_instr steady; redirect squashes the current word and wins over stall.
module instr_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] HALT_INSTR = DEF_HALT_INSTR
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_target,
  output logic [ADDR_WIDTH-1:0]  imem_address,
  input  logic [DATA_WIDTH-1:0]  imem_q,
  output logic                   if_valid,
  output logic [ADDR_WIDTH-1:0]  if_pc,
  output logic [DATA_WIDTH-1:0]  if_instr,
  output logic                   halted,
  output logic                   misalign_err,
  output logic [FETCH_CNT_W-1:0] fetch_count
);
  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] pc_f;
  logic                  accept;
  logic                  halt_hit;

  // Outputs are gated by reset so the register contents are invisible while reset is held.
  assign if_valid = (state == ST_RUN) && !reset && !redirect_valid;
  assign halted   = (state == ST_HALT) && !reset;
  assign if_pc    = pc_f;
  assign if_instr = imem_q;
  assign accept   = if_valid && !stall;
  assign halt_hit = accept && (imem_q == HALT_INSTR);

  fetch_pc_sel #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc_sel (
    .reset           (reset),
    .state           (state),
    .pc_f            (pc_f),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt_hit        (halt_hit),
    .next_pc         (imem_address)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_BOOT;
      pc_f         <= RESET_PC;
      fetch_count  <= '0;
      misalign_err <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN:  if (halt_hit) state <= ST_HALT;
        ST_HALT: state <= ST_HALT;
        default: state <= ST_BOOT;
      endcase
      // pc_f tracks the address the ROM just registered, so q always pairs with pc_f.
      pc_f <= imem_address;
      if (accept)
        fetch_count <= fetch_count + 1'b1;
      misalign_err <= redirect_valid && (redirect_target[1:0] != 2'b00) && (state == ST_RUN);
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: sync-read ROM model, directed scenarios with literal expectations,
// then randomized stall/redirect/reset traffic checked every cycle against a behavioural model.
module tb_instr_fetch_unit;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          stall;
  logic          redirect_valid;
  logic [AW-1:0] redirect_target;
  logic [AW-1:0] imem_address;
  logic [DW-1:0] imem_q;
  logic          if_valid;
  logic [AW-1:0] if_pc;
  logic [DW-1:0] if_instr;
  logic          halted;
  logic          misalign_err;
  logic [15:0]   fetch_count;

  always #5 clock = ~clock;

  instr_fetch_unit #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RESET_PC   (10'd0),
    .HALT_INSTR (32'hFFFF_FFFF)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_address    (imem_address),
    .imem_q          (imem_q),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .halted          (halted),
    .misalign_err    (misalign_err),
    .fetch_count     (fetch_count)
  );

  // Byte-addressed sync-read ROM: word at address a is 32'h1000_0000 + a unless patched.
  logic [31:0] rom [0:1023];
  always @(posedge clock) imem_q <= rom[imem_address];

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: where the fetcher is, what it has counted, whether it is booting/halted.
  logic          m_known = 1'b0;
  logic          m_boot  = 1'b0;
  logic          m_halt  = 1'b0;
  logic          m_mis   = 1'b0;
  logic [AW-1:0] m_pc    = '0;
  logic [15:0]   m_count = '0;

  always @(negedge clock) begin : compare
    logic [AW-1:0] npc;
    logic          acc;
    logic          is_halt;
    if (m_known) begin
      chk("fetch_count", 32'(fetch_count), 32'(m_count));
      chk("misalign_err", 32'(misalign_err), 32'(m_mis));
    end
    if (reset) begin
      chk("rst_addr", 32'(imem_address), 32'h0);
      chk("rst_valid", 32'(if_valid), 32'h0);
      chk("rst_halted", 32'(halted), 32'h0);
      m_known <= 1'b1;
      m_boot  <= 1'b1;
      m_halt  <= 1'b0;
      m_pc    <= '0;
      m_count <= '0;
      m_mis   <= 1'b0;
    end else if (m_boot) begin
      chk("boot_addr", 32'(imem_address), 32'h0);
      chk("boot_valid", 32'(if_valid), 32'h0);
      chk("boot_halted", 32'(halted), 32'h0);
      m_boot <= 1'b0;
      m_pc   <= '0;
      m_mis  <= 1'b0;
    end else if (m_halt) begin
      chk("halt_addr", 32'(imem_address), 32'(m_pc));
      chk("halt_valid", 32'(if_valid), 32'h0);
      chk("halt_halted", 32'(halted), 32'h1);
      m_mis <= 1'b0;
    end else begin
      chk("run_valid", 32'(if_valid), 32'(!redirect_valid));
      chk("run_halted", 32'(halted), 32'h0);
      if (!redirect_valid) begin
        chk("run_pc", 32'(if_pc), 32'(m_pc));
        chk("run_instr", if_instr, rom[m_pc]);
      end
      acc     = !redirect_valid && !stall;
      is_halt = (rom[m_pc] == 32'hFFFF_FFFF);
      if (redirect_valid)
        npc = redirect_target & 10'h3FC;
      else if (stall || is_halt)
        npc = m_pc;
      else
        npc = m_pc + 10'd4;
      chk("run_addr", 32'(imem_address), 32'(npc));
      m_pc <= npc;
      if (acc) m_count <= m_count + 16'd1;
      if (acc && is_halt) m_halt <= 1'b1;
      m_mis <= redirect_valid && (redirect_target[1:0] != 2'b00);
    end
  end

  // Inputs change #1 after the rising edge; the task returns at the following falling edge.
  task automatic drive(input logic r, input logic s, input logic rv, input logic [AW-1:0] rt);
    @(posedge clock);
    #1;
    reset           = r;
    stall           = s;
    redirect_valid  = rv;
    redirect_target = rt;
    @(negedge clock);
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) rom[a] = 32'h1000_0000 + 32'(a);
    reset           = 1'b1;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;

    // Reset, boot bubble, sequential fetch
    drive(1, 0, 0, 10'h0);
    drive(1, 0, 0, 10'h0);
    drive(0, 0, 0, 10'h0);
    chk("t1_boot_valid", 32'(if_valid), 32'h0);
    chk("t1_boot_addr", 32'(imem_address), 32'h0);
    drive(0, 0, 0, 10'h0);
    chk("t1_pc0", 32'(if_pc), 32'h0);
    chk("t1_instr0", if_instr, 32'h1000_0000);
    chk("t1_cnt0", 32'(fetch_count), 32'd0);
    drive(0, 0, 0, 10'h0);
    chk("t1_pc4", 32'(if_pc), 32'h4);
    chk("t1_instr4", if_instr, 32'h1000_0004);
    chk("t1_cnt1", 32'(fetch_count), 32'd1);

    // Stall three cycles at pc 8, then release
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 10'h0);
      chk("t2_stall_pc", 32'(if_pc), 32'h8);
      chk("t2_stall_instr", if_instr, 32'h1000_0008);
      chk("t2_stall_addr", 32'(imem_address), 32'h8);
      chk("t2_stall_cnt", 32'(fetch_count), 32'd2);
    end
    drive(0, 0, 0, 10'h0);
    chk("t2_release_pc", 32'(if_pc), 32'h8);
    chk("t2_release_cnt", 32'(fetch_count), 32'd2);
    drive(0, 0, 0, 10'h0);
    chk("t2_pc12", 32'(if_pc), 32'hC);
    chk("t2_cnt3", 32'(fetch_count), 32'd3);

    // Redirect overriding stall at pc 16
    drive(0, 1, 1, 10'h40);
    chk("t3_pc16", 32'(if_pc), 32'h10);
    chk("t3_squash", 32'(if_valid), 32'h0);
    chk("t3_addr", 32'(imem_address), 32'h40);
    drive(0, 0, 0, 10'h0);
    chk("t3_valid", 32'(if_valid), 32'h1);
    chk("t3_pc", 32'(if_pc), 32'h40);
    chk("t3_instr", if_instr, 32'h1000_0040);

    // Misaligned redirect
    drive(0, 0, 1, 10'h43);
    chk("t4_addr", 32'(imem_address), 32'h40);
    chk("t4_mis_before", 32'(misalign_err), 32'h0);
    drive(0, 0, 0, 10'h0);
    chk("t4_pc", 32'(if_pc), 32'h40);
    chk("t4_mis_pulse", 32'(misalign_err), 32'h1);
    drive(0, 0, 0, 10'h0);
    chk("t4_mis_clear", 32'(misalign_err), 32'h0);
    chk("t4_pc44", 32'(if_pc), 32'h44);

    // Wrap-around at the top of the address space
    drive(0, 0, 1, 10'h3FC);
    drive(0, 0, 0, 10'h0);
    chk("t5_pc_top", 32'(if_pc), 32'h3FC);
    chk("t5_instr_top", if_instr, 32'h1000_03FC);
    drive(0, 0, 0, 10'h0);
    chk("t5_pc_wrap", 32'(if_pc), 32'h0);
    chk("t5_instr_wrap", if_instr, 32'h1000_0000);

    // Halt word at 0x20
    drive(1, 0, 0, 10'h0);
    rom[10'h20] = 32'hFFFF_FFFF;
    drive(1, 0, 0, 10'h0);
    drive(0, 0, 0, 10'h0);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 10'h0);
    drive(0, 0, 0, 10'h0);
    chk("t6_halt_pc", 32'(if_pc), 32'h20);
    chk("t6_halt_word", if_instr, 32'hFFFF_FFFF);
    chk("t6_halt_valid", 32'(if_valid), 32'h1);
    drive(0, 0, 0, 10'h0);
    chk("t6_halted", 32'(halted), 32'h1);
    chk("t6_hvalid", 32'(if_valid), 32'h0);
    chk("t6_haddr", 32'(imem_address), 32'h20);
    chk("t6_hcnt", 32'(fetch_count), 32'd9);
    drive(0, 0, 1, 10'h100);
    chk("t6_redir_ignored", 32'(imem_address), 32'h20);
    chk("t6_still_halted", 32'(halted), 32'h1);
    drive(1, 0, 0, 10'h0);
    chk("t6_rst_halted", 32'(halted), 32'h0);
    drive(0, 0, 0, 10'h0);
    chk("t6_boot_valid", 32'(if_valid), 32'h0);
    drive(0, 0, 0, 10'h0);
    chk("t6_restart_pc", 32'(if_pc), 32'h0);
    chk("t6_restart_valid", 32'(if_valid), 32'h1);

    // Randomized traffic, with an occasional halt word and reset
    drive(1, 0, 0, 10'h0);
    rom[10'h20]  = 32'h1000_0020;
    rom[10'h180] = 32'hFFFF_FFFF;
    drive(1, 0, 0, 10'h0);
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0,
            AW'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
